// File: rtl/adc_avg_if.sv
// adc_avg_if: signal bundle between the averaging sequencer, the SAR ADC FSM
// control path and the downstream valid/ready consumer.
//   enable      : run conversions while high
//   st_conv     : start-conversion pulse to the ADC FSM
//   adc_done    : ADC FSM done level (rising edge = result valid)
//   result      : ADC FSM result, stable while adc_done is high
//   out_data    : averaged result
//   out_valid   : out_data valid, held until accepted
//   out_ready   : downstream accept
//   busy        : sequencer not idle
//   err_timeout : sticky conversion-timeout flag
// master = sequencer side, slave = environment (ADC FSM + consumer + control).
interface adc_avg_if #(
  parameter int DATA_W = 12
);
  logic              enable;
  logic              st_conv;
  logic              adc_done;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  enable, adc_done, result, out_ready,
    output st_conv, out_data, out_valid, busy, err_timeout
  );

  modport slave (
    output enable, adc_done, result, out_ready,
    input  st_conv, out_data, out_valid, busy, err_timeout
  );
endinterface

// File: rtl/adc_avg_sequencer.sv
// adc_avg_sequencer: paces st_conv pulses to the SAR ADC FSM, captures each
// result on the adc_done rising edge, accumulates 2**LOG2_AVG samples and
// presents the truncated mean on a valid/ready stream. A conversion that does
// not finish within TIMEOUT cycles sets a sticky error and is dropped.
// Ports:
//   clk : clock (shared with the ADC FSM control path)
//   rst : synchronous active-high reset
//   bus : adc_avg_if.master (enable, st_conv, adc_done, result, out_data,
//         out_valid, out_ready, busy, err_timeout)
module adc_avg_sequencer #(
  parameter int DATA_W      = 12,
  parameter int LOG2_AVG    = 2,
  parameter int CONV_PERIOD = 30,
  parameter int ST_PULSE    = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic      clk,
  input  logic      rst,
  adc_avg_if.master bus
);

  localparam int NSAMP = 1 << LOG2_AVG;
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int SC_W  = LOG2_AVG + 1;
  localparam int CNT_W = $clog2(((TIMEOUT > ST_PULSE) ? TIMEOUT : ST_PULSE) + 1);
  localparam int PER_W = $clog2(CONV_PERIOD + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ACCUM, S_HOLD, S_OUTPUT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // st_conv pulse length, then WAIT timeout
  logic [PER_W-1:0]  per_q, per_d;     // cycles left until the next st_conv may rise
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SC_W-1:0]   scnt_q, scnt_d;
  logic              done_q;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              err_q, err_d;

  logic              done_rise;
  logic              per_done;
  logic [SC_W-1:0]   scnt_inc;

  assign done_rise = bus.adc_done & ~done_q;
  assign per_done  = (per_q == '0);
  assign scnt_inc  = scnt_q + SC_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_done ? per_q : per_q - PER_W'(1);
    acc_d       = acc_q;
    scnt_d      = scnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d = S_START;
          cnt_d   = '0;
          // Loaded one short: START itself is the first cycle of the period.
          per_d   = PER_W'(CONV_PERIOD - 1);
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(ST_PULSE - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          state_d = S_ACCUM;
          acc_d   = acc_q + ACC_W'(bus.result);
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_HOLD;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACCUM: begin
        if (scnt_inc == SC_W'(NSAMP)) begin
          out_data_d  = DATA_W'(acc_q >> LOG2_AVG);
          out_valid_d = 1'b1;
          acc_d       = '0;
          scnt_d      = '0;
          state_d     = S_OUTPUT;
        end else begin
          scnt_d  = scnt_inc;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (per_done) begin
          if (bus.enable) begin
            state_d = S_START;
            cnt_d   = '0;
            per_d   = PER_W'(CONV_PERIOD - 1);
          end else begin
            // Partial average is abandoned when sampling stops.
            acc_d   = '0;
            scnt_d  = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      per_q       <= '0;
      acc_q       <= '0;
      scnt_q      <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      acc_q       <= acc_d;
      scnt_q      <= scnt_d;
      done_q      <= bus.adc_done;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.st_conv     = (state_q == S_START);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.err_timeout = err_q;

endmodule
